alu_multicycle: RTL and testbench

- Parametrised successor to the core ALU; a single issue port takes one operation at a time.
- Single-cycle ops: logic, add/sub, compare.
- Iterative ops: shifts (SHIFT_STEP bits/cycle), shift-add multiply, restoring divide/remainder.
- Valid/ready handshakes on input and output let the issue stage stall cleanly instead of polling an idle flag.

---
 rtl/alu_multicycle.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, iterative shift,
// shift-add multiply and restoring divide behind valid/ready handshakes.
// Ports: clk, rst_n, in_valid/in_ready, op, operand_a, operand_b,
//   out_valid/out_ready, result, overflow, div_by_zero, invalid_op.
module alu_multicycle #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int SHIFT_STEP   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   operand_a,
  input  logic [DATA_WIDTH-1:0]   operand_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    div_by_zero,
  output logic                    invalid_op
);
  localparam int W  = DATA_WIDTH;
  localparam int LW = $clog2(DATA_WIDTH);
  localparam int CW = LW + 1;
  localparam logic [LW-1:0] STEP_L = LW'(SHIFT_STEP);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLT  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTU = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLL  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRL  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRA  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIVU = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_REMU = OPCODE_WIDTH'(12);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_MUL, S_DIV, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    K_ONE, K_SHF, K_MUL, K_DIV, K_INV
  } kind_t;

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [W-1:0]            a_q;
  logic [W-1:0]            b_q;
  logic [LW-1:0]           rem_cnt;
  logic [2*W-1:0]          acc;
  logic [2*W-1:0]          mcand;
  logic [W-1:0]            div_rem;
  logic [CW-1:0]           cnt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  wire accept = in_valid && in_ready;

  // Single-cycle datapath and op classification
  logic [W-1:0] sum, diff, alu_res;
  logic         alu_ovf;
  kind_t        kind;

  always_comb begin
    sum     = operand_a + operand_b;
    diff    = operand_a - operand_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    kind    = K_INV;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (operand_a[W-1] == operand_b[W-1])
               && (sum[W-1] != operand_a[W-1]);
        kind    = K_ONE;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (operand_a[W-1] != operand_b[W-1])
               && (diff[W-1] != operand_a[W-1]);
        kind    = K_ONE;
      end
      OP_SLT: begin
        alu_res = W'($signed(operand_a) < $signed(operand_b));
        kind    = K_ONE;
      end
      OP_SLTU: begin
        alu_res = W'(operand_a < operand_b);
        kind    = K_ONE;
      end
      OP_AND: begin
        alu_res = operand_a & operand_b;
        kind    = K_ONE;
      end
      OP_OR: begin
        alu_res = operand_a | operand_b;
        kind    = K_ONE;
      end
      OP_XOR: begin
        alu_res = operand_a ^ operand_b;
        kind    = K_ONE;
      end
      OP_SLL, OP_SRL, OP_SRA: kind = K_SHF;
      OP_MUL:                 kind = K_MUL;
      OP_DIVU, OP_REMU:       kind = K_DIV;
      default:                kind = K_INV;
    endcase
  end

  // Shift step: never shift past the remaining amount
  logic [LW-1:0] step_amt;
  logic [W-1:0]  sh_val;
  logic          sh_last;

  always_comb begin
    step_amt = (rem_cnt < STEP_L) ? rem_cnt : STEP_L;
    sh_last  = (rem_cnt <= STEP_L);
    case (op_q)
      OP_SLL:  sh_val = a_q << step_amt;
      OP_SRL:  sh_val = a_q >> step_amt;
      default: sh_val = $signed(a_q) >>> step_amt;
    endcase
  end

  // Multiply step: b_q is the multiplier
  logic [2*W-1:0] acc_nx;
  logic           mul_last;

  always_comb begin
    acc_nx   = b_q[0] ? acc + mcand : acc;
    mul_last = ((b_q >> 1) == '0);
  end

  // Restoring divide step: a_q shifts out dividend, shifts in quotient
  logic [W:0]   rem_sh;
  logic         ge;
  logic [W-1:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh = {div_rem, a_q[W-1]};
    ge     = (rem_sh >= {1'b0, b_q});
    rem_nx = ge ? W'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
    quo_nx = {a_q[W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_cnt     <= '0;
      acc         <= '0;
      mcand       <= '0;
      div_rem     <= '0;
      cnt         <= '0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      invalid_op  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q        <= op;
            a_q         <= operand_a;
            b_q         <= operand_b;
            result      <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            invalid_op  <= 1'b0;
            case (kind)
              K_ONE: begin
                result   <= alu_res;
                overflow <= alu_ovf;
                state    <= S_DONE;
              end
              K_SHF: begin
                rem_cnt <= operand_b[LW-1:0];
                state   <= S_SHIFT;
              end
              K_MUL: begin
                acc   <= '0;
                mcand <= {{W{1'b0}}, operand_a};
                // zero multiplicand: product is zero, finish at once
                b_q   <= (operand_a == '0) ? '0 : operand_b;
                state <= S_MUL;
              end
              K_DIV: begin
                div_rem <= '0;
                cnt     <= '0;
                state   <= S_DIV;
              end
              default: begin
                invalid_op <= 1'b1;
                state      <= S_DONE;
              end
            endcase
          end
        end
        S_SHIFT: begin
          a_q     <= sh_val;
          rem_cnt <= rem_cnt - step_amt;
          if (sh_last) begin
            result <= sh_val;
            state  <= S_DONE;
          end
        end
        S_MUL: begin
          acc   <= acc_nx;
          mcand <= mcand << 1;
          b_q   <= b_q >> 1;
          if (mul_last) begin
            result   <= acc_nx[W-1:0];
            overflow <= |acc_nx[2*W-1:W];
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          if (b_q == '0) begin
            div_by_zero <= 1'b1;
            result      <= (op_q == OP_DIVU) ? '1 : a_q;
            state       <= S_DONE;
          end else begin
            a_q     <= quo_nx;
            div_rem <= rem_nx;
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
              result <= (op_q == OP_DIVU) ? quo_nx : rem_nx;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle: vector table plus
// hand-written stall, reset-abort and SHIFT_STEP=4 sequences.
module tb_alu_multicycle;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   op;
  logic [W-1:0] a, b;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] result;
  logic         overflow, div_by_zero, invalid_op;

  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [W-1:0] result4;
  logic         overflow4, div_by_zero4, invalid_op4;

  alu_multicycle #(.DATA_WIDTH(W), .OPCODE_WIDTH(4), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(a), .operand_b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .div_by_zero(div_by_zero), .invalid_op(invalid_op)
  );

  alu_multicycle #(.DATA_WIDTH(W), .OPCODE_WIDTH(4), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op), .operand_a(a), .operand_b(b),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .overflow(overflow4),
    .div_by_zero(div_by_zero4), .invalid_op(invalid_op4)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op at #1 after a posedge; returns result, flags, latency.
  task automatic run_op(input bit sel, input logic [3:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input string name,
                        output logic [W-1:0] r, output logic ov,
                        output logic dz, output logic iv,
                        output int lat);
    op = o; a = x; b = y;
    if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
    chk({name, ".in_ready"}, sel ? in_ready4 : in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    lat = 1;
    while (!(sel ? out_valid4 : out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk({name, ".timeout"}, 1, 0);
    r  = sel ? result4 : result;
    ov = sel ? overflow4 : overflow;
    dz = sel ? div_by_zero4 : div_by_zero;
    iv = sel ? invalid_op4 : invalid_op;
    if (sel) out_ready4 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready4 = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         dbz;
    logic         inv;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [W-1:0] r, hold;
    logic         ov, dz, iv;
    int           lat;

    vecs.push_back('{4'd0,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, 0, 1});
    vecs.push_back('{4'd1,  32'h0, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 1});
    vecs.push_back('{4'd1,  32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0, 0, 1});
    vecs.push_back('{4'd2,  32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 1});
    vecs.push_back('{4'd3,  32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0, 1});
    vecs.push_back('{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1});
    vecs.push_back('{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1});
    vecs.push_back('{4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 1});
    vecs.push_back('{4'd7,  32'h1, 32'h25, 32'h20, 0, 0, 0, 6});
    vecs.push_back('{4'd8,  32'h80000000, 32'h4, 32'h08000000, 0, 0, 0, 5});
    vecs.push_back('{4'd9,  32'h80000000, 32'd31, 32'hFFFFFFFF, 0, 0, 0, 32});
    vecs.push_back('{4'd7,  32'h1234, 32'h0, 32'h1234, 0, 0, 0, 2});
    vecs.push_back('{4'd10, 32'h10000, 32'h10000, 32'h0, 1, 0, 0, 18});
    vecs.push_back('{4'd10, 32'h0, 32'd123, 32'h0, 0, 0, 0, 2});
    vecs.push_back('{4'd10, 32'd123, 32'h0, 32'h0, 0, 0, 0, 2});
    vecs.push_back('{4'd10, 32'd3, 32'd5, 32'd15, 0, 0, 0, 4});
    vecs.push_back('{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1, 0, 0, 33});
    vecs.push_back('{4'd11, 32'd100, 32'd7, 32'd14, 0, 0, 0, 33});
    vecs.push_back('{4'd12, 32'd100, 32'd7, 32'd2, 0, 0, 0, 33});
    vecs.push_back('{4'd11, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 1, 0, 2});
    vecs.push_back('{4'd12, 32'd5, 32'd0, 32'd5, 0, 1, 0, 2});
    vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 33});
    vecs.push_back('{4'd15, 32'd9, 32'd9, 32'h0, 0, 0, 1, 1});
    vecs.push_back('{4'd0,  32'd2, 32'd3, 32'd5, 0, 0, 0, 1});

    // Reset held with in_valid high
    rst_n = 1'b0;
    in_valid = 1'b1; in_valid4 = 1'b1;
    out_ready = 1'b0; out_ready4 = 1'b0;
    op = 4'd0; a = 32'h7FFFFFFF; b = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.flags", {overflow, div_by_zero, invalid_op}, 0);
    in_valid = 1'b0; in_valid4 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b,
             $sformatf("v%0d", i), r, ov, dz, iv, lat);
      chk($sformatf("v%0d.result", i), r, vecs[i].res);
      chk($sformatf("v%0d.overflow", i), ov, vecs[i].ovf);
      chk($sformatf("v%0d.div_by_zero", i), dz, vecs[i].dbz);
      chk($sformatf("v%0d.invalid_op", i), iv, vecs[i].inv);
      chk($sformatf("v%0d.latency", i), lat, vecs[i].lat);
    end

    // SHIFT_STEP=4 instance: same shift, fewer cycles
    run_op(1'b1, 4'd7, 32'h1, 32'h25, "step4", r, ov, dz, iv, lat);
    chk("step4.result", r, 32'h20);
    chk("step4.latency", lat, 3);
    run_op(1'b1, 4'd9, 32'h80000000, 32'd31, "step4sra", r, ov, dz, iv, lat);
    chk("step4sra.result", r, 32'hFFFFFFFF);
    chk("step4sra.latency", lat, 9);

    // Stall in DONE with in_valid and operands toggling
    op = 4'd10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("stall.timeout", 1, 0);
    chk("stall.result0", result, 32'd15);
    hold = result;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      op = 4'(k);
      a = 32'(k * 7);
      b = 32'(k + 1);
      @(posedge clk); #1;
      chk($sformatf("stall%0d.in_ready", k), in_ready, 0);
      chk($sformatf("stall%0d.out_valid", k), out_valid, 1);
      chk($sformatf("stall%0d.result", k), result, hold);
    end
    op = 4'd0; a = 32'd2; b = 32'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall.ready_after", in_ready, 1);
    chk("stall.valid_after", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall.next_valid", out_valid, 1);
    chk("stall.next_result", result, 32'd5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-DIV aborts immediately
    op = 4'd11; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("middiv.busy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("middiv.out_valid", out_valid, 0);
    chk("middiv.in_ready", in_ready, 1);
    chk("middiv.result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("middiv.idle_valid", out_valid, 0);
    run_op(1'b0, 4'd14, 32'd1, 32'd1, "inv14", r, ov, dz, iv, lat);
    chk("inv14.result", r, 0);
    chk("inv14.invalid_op", iv, 1);
    chk("inv14.latency", lat, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
